// File: rtl/seq_mul_unit.sv
// Iterative shift-add 32x32->64 multiplier; ready_o 32 edges after accept (1 edge for zero operands under MUL_EARLY_OUT_EN).
// Backpressure: result held in DONE while start_i stays high; dropping start_i or annul_i returns to IDLE.
module seq_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 signed_mul_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
`ifdef MUL_EARLY_OUT_EN
  logic                 zero_q, zero_d;
`endif

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     acc_add, acc_shr;
  logic [2*WIDTH-1:0]   prod, prod_final;

  // Magnitudes as unsigned: 0x80000000 negates to itself, which is exactly 2^31.
  assign a_mag = (signed_mul_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
  assign b_mag = (signed_mul_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

  assign sum        = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
  assign acc_add    = acc_q[0] ? {sum, acc_q[WIDTH-1:0]} : acc_q;
  assign acc_shr    = acc_add >> 1;
  assign prod       = acc_shr[2*WIDTH-1:0];
  assign prod_final = neg_q ? (~prod + 1'b1) : prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef MUL_EARLY_OUT_EN
    zero_d   = zero_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          state_d = CALC;
          cnt_d   = '0;
          mcand_d = a_mag;
          acc_d   = {{(WIDTH+1){1'b0}}, b_mag};
          neg_d   = signed_mul_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`ifdef MUL_EARLY_OUT_EN
          zero_d  = (a_mag == '0) || (b_mag == '0);
`endif
        end
      end
      CALC: begin
        if (annul_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
`ifdef MUL_EARLY_OUT_EN
        else if (zero_q) begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = '0;
        end
`endif
        else begin
          acc_d = acc_shr;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = prod_final;
          end
        end
      end
      DONE: begin
        // No re-trigger: a fresh start needs start_i to go low first.
        if (annul_i || !start_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
`ifdef MUL_EARLY_OUT_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef MUL_EARLY_OUT_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Scoreboard bench for seq_mul_unit: driver pushes expected product/latency, negedge monitor checks.
module tb_seq_mul_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        signed_mul_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  seq_mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .signed_mul_i(signed_mul_i),
    .a_i(a_i), .b_i(b_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
    if (a == 0 || b == 0) return 1;
`endif
    return 32;
  endfunction

  // Monitor: checks each ready_o rising against the scoreboard, stability while high, zero while low.
  initial begin
    logic        rdy_prev;
    logic [63:0] cur;
    exp_t        e;
    rdy_prev = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (ready_o && !rdy_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: ready_o rose with no operation outstanding, result_o=%h", result_o);
        end else begin
          e = exp_q.pop_front();
          cur = e.res;
          if (result_o !== e.res) begin
            errors++;
            $display("FAIL product: got %h expected %h", result_o, e.res);
          end
          checks++;
          if (cyc - e.acc != e.lat) begin
            errors++;
            $display("FAIL latency: got %0d edges expected %0d", cyc - e.acc, e.lat);
          end
        end
      end else if (ready_o) begin
        checks++;
        if (result_o !== cur) begin
          errors++;
          $display("FAIL hold_stable: got %h expected %h", result_o, cur);
        end
      end else begin
        checks++;
        if (result_o !== 64'd0) begin
          errors++;
          $display("FAIL idle_zero: result_o=%h expected 0 while ready_o low", result_o);
        end
      end
      rdy_prev = ready_o;
    end
  end

  task automatic check_quiet(input string name);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL %s: ready_o=%b result_o=%h expected 0/0", name, ready_o, result_o);
    end
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit drop_early);
    bit seen;
    exp_t e;
    seen = 1'b0;
    @(negedge clk);
    signed_mul_i = sgn; a_i = a; b_i = b; start_i = 1'b1;
    e.res = ref_mul(sgn, a, b);
    e.lat = ref_lat(a, b);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
      else begin
        a_i = $urandom; b_i = $urandom; signed_mul_i = 1'($urandom);
        if (drop_early && i >= 5) start_i = 1'b0;
      end
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL timeout: ready_o=%b after 100 cycles, expected 1", ready_o);
      start_i = 1'b0;
      exp_q.delete();
      return;
    end
    if (start_i) begin
      repeat (hold) begin
        @(negedge clk);
        a_i = $urandom; b_i = $urandom; signed_mul_i = 1'($urandom);
      end
      start_i = 1'b0;
    end
    @(posedge clk);
    #1 check_quiet("drop_release");
  endtask

  task automatic annul_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_mul_i = 1'b0; a_i = a; b_i = b; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    repeat (2) @(negedge clk);
    annul_i = 1'b0;
    repeat (40) @(negedge clk);
    check_quiet("after_annul");
  endtask

  initial begin
    logic [31:0] corner [4];
    logic [31:0] ra, rb;
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'h8000_0000; corner[3] = 32'hFFFF_FFFF;

    repeat (2) @(negedge clk);
    check_quiet("reset_state");
    resetn = 1'b1;

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 5, 1'b0);
    run_op(1'b0, 32'd123456, 32'd654321, 0, 1'b0);

    annul_op(32'hDEAD_BEEF, 32'h1234_5678);
    run_op(1'b0, 32'd6, 32'd7, 1, 1'b0);

    // Reset during CALC, away from any clock edge.
    @(negedge clk);
    signed_mul_i = 1'b0; a_i = 32'hFFFF_0000; b_i = 32'h0000_FFFF; start_i = 1'b1;
    repeat (21) @(negedge clk);
    #3 resetn = 1'b0;
    #1 check_quiet("reset_mid_calc");
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);

    run_op(1'b0, 32'd0, 32'h1234_5678, 2, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
    run_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0001, 0, 1'b1);

    // Reset while DONE holds a result: outputs must clear without a clock edge.
    @(negedge clk);
    signed_mul_i = 1'b0; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1;
    begin
      exp_t e;
      e.res = ref_mul(1'b0, 32'd9, 32'd9); e.lat = ref_lat(32'd9, 32'd9); e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    repeat (34) @(negedge clk);
    #3 resetn = 1'b0;
    #1 check_quiet("reset_in_done");
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int n = 0; n < 14; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      run_op(1'($urandom), ra, rb, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
    end

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d results never presented, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
